caliptra_apb_arbiter: RTL and testbench

Two-requester APB arbiter that shares the single Caliptra APB slave port (the wrapper's PADDR/PSEL/PENABLE/... port) between the PS-side host APB master and a second on-FPGA master, such as a JTAG-to-APB bridge or a mailbox test sequencer.
- Round-robin grant; one transfer at a time; all downstream APB signals registered.
- Sits in the FPGA top between the APB sources and caliptra_wrapper_top.

---
 rtl/caliptra_apb_arb_pkg.sv | 26 ++
 rtl/caliptra_rr_arb2.sv | 20 ++
 rtl/caliptra_apb_arbiter.sv | 177 +++++++++++++++++
 tb/tb_caliptra_apb_arbiter.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caliptra_apb_arb_pkg.sv
// Shared types and constants for the two-requester Caliptra APB arbiter.
package caliptra_apb_arb_pkg;

    localparam int PKG_ADDR_W = 32;
    localparam int PKG_DATA_W = 32;
    localparam int PKG_USER_W = 32;

    // Read data returned to a requester whose transfer was cut short by the watchdog.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_0A0B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] paddr;
        logic                  pwrite;
        logic [PKG_DATA_W-1:0] pwdata;
        logic [2:0]            pprot;
        logic [PKG_USER_W-1:0] pauser;
    } apb_req_t;

endpackage

// File: rtl/caliptra_rr_arb2.sv
// Combinational two-way round-robin pick; the caller owns the last_grant register.
module caliptra_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_grant;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/caliptra_apb_arbiter.sv
// Shares the Caliptra APB slave port between two APB masters, one transfer at a time.
// Optional ACCESS-phase watchdog enabled by defining CALIPTRA_APB_ARB_TIMEOUT_EN.
module caliptra_apb_arbiter
    import caliptra_apb_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int USER_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              s0_psel,
    input  logic              s0_penable,
    input  logic              s0_pwrite,
    input  logic [ADDR_W-1:0] s0_paddr,
    input  logic [DATA_W-1:0] s0_pwdata,
    input  logic [2:0]        s0_pprot,
    input  logic [USER_W-1:0] s0_pauser,
    output logic [DATA_W-1:0] s0_prdata,
    output logic              s0_pready,
    output logic              s0_pslverr,
    input  logic              s1_psel,
    input  logic              s1_penable,
    input  logic              s1_pwrite,
    input  logic [ADDR_W-1:0] s1_paddr,
    input  logic [DATA_W-1:0] s1_pwdata,
    input  logic [2:0]        s1_pprot,
    input  logic [USER_W-1:0] s1_pauser,
    output logic [DATA_W-1:0] s1_prdata,
    output logic              s1_pready,
    output logic              s1_pslverr,
    output logic              m_psel,
    output logic              m_penable,
    output logic              m_pwrite,
    output logic [ADDR_W-1:0] m_paddr,
    output logic [DATA_W-1:0] m_pwdata,
    output logic [2:0]        m_pprot,
    output logic [USER_W-1:0] m_pauser,
    input  logic [DATA_W-1:0] m_prdata,
    input  logic              m_pready,
    input  logic              m_pslverr,
    output logic              arb_busy,
    output logic              arb_grant
);

    arb_state_e  state_reg, state_next;
    apb_req_t    req_reg;
    apb_req_t    req_in [2];
    logic        last_grant_reg;
    logic        arb_grant_reg;
    logic        m_psel_reg, m_penable_reg;
    logic        gnt_valid, gnt_idx;
    logic        timeout_hit;
    logic        rsp_fire;
    logic        rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              pready_reg  [2];
    logic              pslverr_reg [2];
    logic [DATA_W-1:0] prdata_reg  [2];

    // Requester penable carries no arbitration meaning; the requester owns its protocol.
    logic unused_penable;
    assign unused_penable = s0_penable ^ s1_penable;

    assign req_in[0] = '{paddr: PKG_ADDR_W'(s0_paddr), pwrite: s0_pwrite,
                         pwdata: PKG_DATA_W'(s0_pwdata), pprot: s0_pprot,
                         pauser: PKG_USER_W'(s0_pauser)};
    assign req_in[1] = '{paddr: PKG_ADDR_W'(s1_paddr), pwrite: s1_pwrite,
                         pwdata: PKG_DATA_W'(s1_pwdata), pprot: s1_pprot,
                         pauser: PKG_USER_W'(s1_pauser)};

    caliptra_rr_arb2 u_rr (
        .req        ({s1_psel, s0_psel}),
        .last_grant (last_grant_reg),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] tmo_cnt_reg;

    always_ff @(posedge core_clk) begin
        if (core_rst || state_reg == SETUP) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ACCESS && !m_pready) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == ACCESS) && !m_pready &&
                         (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (gnt_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (m_pready || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A real slave response always beats a watchdog expiry in the same cycle.
    assign rsp_fire  = (state_reg == ACCESS) && (m_pready || timeout_hit);
    assign rsp_rdata = m_pready ? m_prdata : DATA_W'(TIMEOUT_RDATA);
    assign rsp_err   = m_pready ? m_pslverr : 1'b1;

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            req_reg        <= '0;
            last_grant_reg <= 1'b1;
            arb_grant_reg  <= 1'b0;
            m_psel_reg     <= 1'b0;
            m_penable_reg  <= 1'b0;
        end else begin
            if (state_reg == IDLE && gnt_valid) begin
                req_reg        <= req_in[gnt_idx];
                last_grant_reg <= gnt_idx;
                arb_grant_reg  <= gnt_idx;
            end
            m_psel_reg    <= (state_next == SETUP) || (state_next == ACCESS);
            m_penable_reg <= (state_next == ACCESS);
        end
    end

    // Response registers per requester; data and error stay zero outside the pready pulse.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            always_ff @(posedge core_clk) begin
                if (core_rst) begin
                    pready_reg[gi]  <= 1'b0;
                    pslverr_reg[gi] <= 1'b0;
                    prdata_reg[gi]  <= '0;
                end else if (rsp_fire && arb_grant_reg == 1'(gi)) begin
                    pready_reg[gi]  <= 1'b1;
                    pslverr_reg[gi] <= rsp_err;
                    prdata_reg[gi]  <= rsp_rdata;
                end else begin
                    pready_reg[gi]  <= 1'b0;
                    pslverr_reg[gi] <= 1'b0;
                    prdata_reg[gi]  <= '0;
                end
            end
        end
    endgenerate

    assign m_psel     = m_psel_reg;
    assign m_penable  = m_penable_reg;
    assign m_pwrite   = req_reg.pwrite;
    assign m_paddr    = ADDR_W'(req_reg.paddr);
    assign m_pwdata   = DATA_W'(req_reg.pwdata);
    assign m_pprot    = req_reg.pprot;
    assign m_pauser   = USER_W'(req_reg.pauser);
    assign s0_pready  = pready_reg[0];
    assign s0_pslverr = pslverr_reg[0];
    assign s0_prdata  = prdata_reg[0];
    assign s1_pready  = pready_reg[1];
    assign s1_pslverr = pslverr_reg[1];
    assign s1_prdata  = prdata_reg[1];
    assign arb_busy   = (state_reg != IDLE);
    assign arb_grant  = arb_grant_reg;

endmodule

// File: tb/tb_caliptra_apb_arbiter.sv
// Scoreboard bench for caliptra_apb_arbiter with a programmable wait-state APB slave.
module tb_caliptra_apb_arbiter;
    import caliptra_apb_arb_pkg::*;

    typedef struct {
        logic        idx;
        logic [31:0] data;
        logic        err;
        int          cyc;
        logic        grant;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [2:0]  prot;
        logic [31:0] user;
    } dn_t;

    logic core_clk = 1'b0;
    logic core_rst = 1'b1;
    always #5 core_clk = ~core_clk;

    logic        s0_psel, s0_penable, s0_pwrite, s1_psel, s1_penable, s1_pwrite;
    logic [31:0] s0_paddr, s0_pwdata, s0_pauser, s1_paddr, s1_pwdata, s1_pauser;
    logic [2:0]  s0_pprot, s1_pprot;
    logic [31:0] s0_prdata, s1_prdata;
    logic        s0_pready, s0_pslverr, s1_pready, s1_pslverr;
    logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic [31:0] m_paddr, m_pwdata, m_pauser, m_prdata;
    logic [2:0]  m_pprot;
    logic        arb_busy, arb_grant;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    rsp_t exp_q[$], obs_q[$];
    dn_t  exp_dn[$], obs_dn[$];

    caliptra_apb_arbiter #(
        .ADDR_W(32), .DATA_W(32), .USER_W(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .s0_psel(s0_psel), .s0_penable(s0_penable), .s0_pwrite(s0_pwrite),
        .s0_paddr(s0_paddr), .s0_pwdata(s0_pwdata), .s0_pprot(s0_pprot),
        .s0_pauser(s0_pauser), .s0_prdata(s0_prdata), .s0_pready(s0_pready),
        .s0_pslverr(s0_pslverr),
        .s1_psel(s1_psel), .s1_penable(s1_penable), .s1_pwrite(s1_pwrite),
        .s1_paddr(s1_paddr), .s1_pwdata(s1_pwdata), .s1_pprot(s1_pprot),
        .s1_pauser(s1_pauser), .s1_prdata(s1_prdata), .s1_pready(s1_pready),
        .s1_pslverr(s1_pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pprot(m_pprot),
        .m_pauser(m_pauser), .m_prdata(m_prdata), .m_pready(m_pready),
        .m_pslverr(m_pslverr),
        .arb_busy(arb_busy), .arb_grant(arb_grant)
    );

    // Slave model: ready after slv_wait ACCESS cycles unless slv_never is set.
    int          slv_wait = 0;
    int          acc_cnt = 0;
    logic        slv_never = 1'b0;
    logic        slv_echo = 1'b0;
    logic        slv_err = 1'b0;
    logic [31:0] slv_rdata = 32'h0;

    always @(posedge core_clk) begin
        cyc <= cyc + 1;
        if (!(m_psel && m_penable) || m_pready) acc_cnt <= 0;
        else acc_cnt <= acc_cnt + 1;
    end
    assign m_pready  = m_psel && m_penable && !slv_never && (acc_cnt == slv_wait);
    assign m_prdata  = slv_echo ? ~m_paddr : slv_rdata;
    assign m_pslverr = slv_err;

    initial forever begin
        @(posedge core_clk);
        if (!core_rst && m_psel && m_penable && m_pready)
            obs_dn.push_back('{m_paddr, m_pwrite, m_pwdata, m_pprot, m_pauser});
    end

    // Response monitor: logs pready pulses and checks the idle-zero and single-pulse rules.
    initial begin
        logic prev0, prev1;
        prev0 = 1'b0;
        prev1 = 1'b0;
        forever begin
            @(negedge core_clk);
            if (core_rst) begin
                prev0 = 1'b0;
                prev1 = 1'b0;
            end else begin
                n_cmp++;
                if ((!s0_pready && (s0_prdata !== 32'h0 || s0_pslverr !== 1'b0)) ||
                    (!s1_pready && (s1_prdata !== 32'h0 || s1_pslverr !== 1'b0))) begin
                    n_err++;
                    $display("FAIL rsp_idle_zero cyc=%0d actual s0=%h/%b s1=%h/%b required zero when pready low",
                             cyc, s0_prdata, s0_pslverr, s1_prdata, s1_pslverr);
                end
                n_cmp++;
                if ((s0_pready && prev0) || (s1_pready && prev1) || (s0_pready && s1_pready)) begin
                    n_err++;
                    $display("FAIL pready_pulse cyc=%0d actual s0=%b s1=%b prev=%b%b required single one-cycle pulse",
                             cyc, s0_pready, s1_pready, prev0, prev1);
                end
                if (s0_pready) obs_q.push_back('{1'b0, s0_prdata, s0_pslverr, cyc, arb_grant});
                if (s1_pready) obs_q.push_back('{1'b1, s1_prdata, s1_pslverr, cyc, arb_grant});
                prev0 = s0_pready;
                prev1 = s1_pready;
            end
        end
    end

    function automatic dn_t mk_dn(input int idx, input int i, input logic [31:0] a0,
                                  input logic [31:0] wd0, input logic wr);
        return '{a0 + 32'(i * 8), wr, wd0 + 32'(i), (idx != 0) ? 3'b101 : 3'b010,
                 {(idx != 0) ? 16'h5A5A : 16'hA5A5, 16'(i)}};
    endfunction

    // Requester driver: holds psel until each pready, then presents the next request.
    task automatic drive(input int idx, input int n, input logic [31:0] a0,
                         input logic [31:0] wd0, input logic wr);
        dn_t  d;
        logic got;
        for (int i = 0; i < n; i++) begin
            d = mk_dn(idx, i, a0, wd0, wr);
            if (idx == 0) begin
                s0_psel = 1'b1; s0_pwrite = d.wr; s0_paddr = d.addr;
                s0_pwdata = d.wdata; s0_pprot = d.prot; s0_pauser = d.user;
            end else begin
                s1_psel = 1'b1; s1_pwrite = d.wr; s1_paddr = d.addr;
                s1_pwdata = d.wdata; s1_pprot = d.prot; s1_pauser = d.user;
            end
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge core_clk);
                got = (idx == 0) ? s0_pready : s1_pready;
            end
            if (!got) begin
                n_cmp++;
                n_err++;
                $display("FAIL drive_wait req=%0d xfer=%0d actual no pready required pready within 200 cycles", idx, i);
            end
        end
        if (idx == 0) s0_psel = 1'b0;
        else s1_psel = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge core_clk);
        core_rst = 1'b1;
        repeat (2) @(negedge core_clk);
        core_rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge core_clk);
        n_cmp++;
        if ({m_psel, m_penable, arb_busy, arb_grant, s0_pready, s1_pready, s0_pslverr, s1_pslverr} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl actual=%b required=00000000",
                     {m_psel, m_penable, arb_busy, arb_grant, s0_pready, s1_pready, s0_pslverr, s1_pslverr});
        end
        n_cmp++;
        if (m_paddr !== 32'h0 || m_pwdata !== 32'h0 || m_pauser !== 32'h0 || m_pprot !== 3'h0 || m_pwrite !== 1'b0) begin
            n_err++;
            $display("FAIL reset_bus actual addr=%h wdata=%h user=%h prot=%h wr=%b required all zero",
                     m_paddr, m_pwdata, m_pauser, m_pprot, m_pwrite);
        end
        n_cmp++;
        if (s0_prdata !== 32'h0 || s1_prdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdata actual s0=%h s1=%h required 0", s0_prdata, s1_prdata);
        end
        core_rst = 1'b0;
    endtask

    task automatic test_single_write();
        rsp_t e, r;
        dn_t  de, dr;
        int   t0;
        slv_rdata = 32'h0BAD_BEEF;
        @(negedge core_clk);
        t0 = cyc;
        exp_q.push_back('{1'b0, 32'h0BAD_BEEF, 1'b0, t0 + 3, 1'b0});
        exp_dn.push_back(mk_dn(0, 0, 32'h3002_0000, 32'h1234_5678, 1'b1));
        fork
            drive(0, 1, 32'h3002_0000, 32'h1234_5678, 1'b1);
            begin
                @(negedge core_clk);
                n_cmp++;
                if (m_psel !== 1'b1 || m_penable !== 1'b0 || m_paddr !== 32'h3002_0000 || m_pwdata !== 32'h1234_5678) begin
                    n_err++;
                    $display("FAIL single_setup actual psel=%b pen=%b addr=%h wdata=%h required 1 0 30020000 12345678",
                             m_psel, m_penable, m_paddr, m_pwdata);
                end
                @(negedge core_clk);
                n_cmp++;
                if (m_psel !== 1'b1 || m_penable !== 1'b1) begin
                    n_err++;
                    $display("FAIL single_access actual psel=%b pen=%b required 1 1", m_psel, m_penable);
                end
            end
        join
        @(posedge core_clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL single_rsp actual none required idx=%0d cyc=%0d", e.idx, e.cyc);
            end else begin
                r = obs_q.pop_front();
                if (r.idx !== e.idx || r.data !== e.data || r.err !== e.err || r.cyc !== e.cyc || r.grant !== e.idx) begin
                    n_err++;
                    $display("FAIL single_rsp actual idx=%0d data=%h err=%b cyc=%0d grant=%0d required idx=%0d data=%h err=%b cyc=%0d",
                             r.idx, r.data, r.err, r.cyc, r.grant, e.idx, e.data, e.err, e.cyc);
                end
            end
        end
        while (exp_dn.size() > 0) begin
            de = exp_dn.pop_front();
            n_cmp++;
            dr = (obs_dn.size() > 0) ? obs_dn.pop_front() : '{32'hx, 1'bx, 32'hx, 3'hx, 32'hx};
            if (dr.addr !== de.addr || dr.wr !== de.wr || dr.wdata !== de.wdata || dr.prot !== de.prot || dr.user !== de.user) begin
                n_err++;
                $display("FAIL single_dn actual addr=%h wr=%b wdata=%h prot=%h user=%h required addr=%h wr=%b wdata=%h prot=%h user=%h",
                         dr.addr, dr.wr, dr.wdata, dr.prot, dr.user, de.addr, de.wr, de.wdata, de.prot, de.user);
            end
        end
    endtask

    task automatic test_contention();
        rsp_t e, r;
        dn_t  de, dr;
        int   t0;
        do_reset();
        slv_rdata = 32'hCAFE_F00D;
        @(negedge core_clk);
        t0 = cyc;
        exp_q.push_back('{1'b0, 32'hCAFE_F00D, 1'b0, t0 + 3, 1'b0});
        exp_q.push_back('{1'b1, 32'hCAFE_F00D, 1'b0, t0 + 7, 1'b1});
        exp_dn.push_back(mk_dn(0, 0, 32'h3002_0010, 32'h1111_0000, 1'b1));
        exp_dn.push_back(mk_dn(1, 0, 32'h3003_0000, 32'h2222_0000, 1'b0));
        fork
            drive(0, 1, 32'h3002_0010, 32'h1111_0000, 1'b1);
            drive(1, 1, 32'h3003_0000, 32'h2222_0000, 1'b0);
            begin
                @(negedge core_clk);
                n_cmp++;
                if (arb_grant !== 1'b0 || arb_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL contention_grant0 actual grant=%b busy=%b required 0 1", arb_grant, arb_busy);
                end
                repeat (4) @(negedge core_clk);
                n_cmp++;
                if (arb_grant !== 1'b1 || m_psel !== 1'b1) begin
                    n_err++;
                    $display("FAIL contention_grant1 actual grant=%b psel=%b required 1 1", arb_grant, m_psel);
                end
            end
        join
        @(posedge core_clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL contention_rsp actual none required idx=%0d cyc=%0d", e.idx, e.cyc);
            end else begin
                r = obs_q.pop_front();
                if (r.idx !== e.idx || r.data !== e.data || r.err !== e.err || r.cyc !== e.cyc || r.grant !== e.idx) begin
                    n_err++;
                    $display("FAIL contention_rsp actual idx=%0d data=%h err=%b cyc=%0d grant=%0d required idx=%0d data=%h err=%b cyc=%0d",
                             r.idx, r.data, r.err, r.cyc, r.grant, e.idx, e.data, e.err, e.cyc);
                end
            end
        end
        while (exp_dn.size() > 0) begin
            de = exp_dn.pop_front();
            n_cmp++;
            dr = (obs_dn.size() > 0) ? obs_dn.pop_front() : '{32'hx, 1'bx, 32'hx, 3'hx, 32'hx};
            if (dr.addr !== de.addr || dr.wr !== de.wr || dr.wdata !== de.wdata || dr.prot !== de.prot || dr.user !== de.user) begin
                n_err++;
                $display("FAIL contention_dn actual addr=%h wr=%b wdata=%h user=%h required addr=%h wr=%b wdata=%h user=%h",
                         dr.addr, dr.wr, dr.wdata, dr.user, de.addr, de.wr, de.wdata, de.user);
            end
        end
    endtask

    task automatic test_back_to_back();
        rsp_t e, r;
        dn_t  de, dr;
        int   t0;
        logic [31:0] a;
        slv_echo = 1'b1;
        @(negedge core_clk);
        t0 = cyc;
        for (int k = 0; k < 6; k++) begin
            a = ((k % 2) != 0) ? 32'h3003_2000 : 32'h3002_1000;
            exp_q.push_back('{1'(k % 2), ~(a + 32'((k / 2) * 8)), 1'b0, t0 + 3 + 4 * k, 1'(k % 2)});
            exp_dn.push_back(mk_dn(k % 2, k / 2, a, 32'h4444_0000, 1'b0));
        end
        fork
            drive(0, 3, 32'h3002_1000, 32'h4444_0000, 1'b0);
            drive(1, 3, 32'h3003_2000, 32'h4444_0000, 1'b0);
        join
        @(posedge core_clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL b2b_rsp actual none required idx=%0d cyc=%0d", e.idx, e.cyc);
            end else begin
                r = obs_q.pop_front();
                if (r.idx !== e.idx || r.data !== e.data || r.err !== e.err || r.cyc !== e.cyc || r.grant !== e.idx) begin
                    n_err++;
                    $display("FAIL b2b_rsp actual idx=%0d data=%h err=%b cyc=%0d grant=%0d required idx=%0d data=%h err=%b cyc=%0d",
                             r.idx, r.data, r.err, r.cyc, r.grant, e.idx, e.data, e.err, e.cyc);
                end
            end
        end
        while (exp_dn.size() > 0) begin
            de = exp_dn.pop_front();
            n_cmp++;
            dr = (obs_dn.size() > 0) ? obs_dn.pop_front() : '{32'hx, 1'bx, 32'hx, 3'hx, 32'hx};
            if (dr.addr !== de.addr || dr.wr !== de.wr || dr.wdata !== de.wdata || dr.prot !== de.prot || dr.user !== de.user) begin
                n_err++;
                $display("FAIL b2b_dn actual addr=%h wdata=%h prot=%h user=%h required addr=%h wdata=%h prot=%h user=%h",
                         dr.addr, dr.wdata, dr.prot, dr.user, de.addr, de.wdata, de.prot, de.user);
            end
        end
        slv_echo = 1'b0;
    endtask

    // Runs one isolated s-requester transfer and checks its response and downstream record.
    task automatic test_wait_err();
        rsp_t e, r;
        int   t0;
        slv_wait = 5;
        slv_err = 1'b1;
        slv_rdata = 32'h7777_0005;
        @(negedge core_clk);
        t0 = cyc;
        exp_q.push_back('{1'b1, 32'h7777_0005, 1'b1, t0 + 8, 1'b1});
        drive(1, 1, 32'h3003_0040, 32'h0, 1'b0);
        @(posedge core_clk);
        e = exp_q.pop_front();
        n_cmp++;
        r = (obs_q.size() > 0) ? obs_q.pop_front() : '{1'bx, 32'hx, 1'bx, -1, 1'bx};
        if (r.idx !== e.idx || r.data !== e.data || r.err !== e.err || r.cyc !== e.cyc) begin
            n_err++;
            $display("FAIL wait_err_rsp actual idx=%0d data=%h err=%b cyc=%0d required idx=%0d data=%h err=%b cyc=%0d",
                     r.idx, r.data, r.err, r.cyc, e.idx, e.data, e.err, e.cyc);
        end
        n_cmp++;
        if (obs_dn.size() != 1) begin
            n_err++;
            $display("FAIL wait_err_dn actual %0d records required 1", obs_dn.size());
        end
        obs_dn.delete();
        slv_wait = 0;
        slv_err = 1'b0;
    endtask

`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        rsp_t e, r;
        int   t0;
        slv_never = 1'b1;
        @(negedge core_clk);
        t0 = cyc;
        exp_q.push_back('{1'b0, 32'hDEAD_0A0B, 1'b1, t0 + 18, 1'b0});
        drive(0, 1, 32'h3002_0080, 32'h0, 1'b0);
        slv_never = 1'b0;
        slv_wait = 15;
        slv_rdata = 32'h1357_9BDF;
        @(negedge core_clk);
        t0 = cyc;
        exp_q.push_back('{1'b0, 32'h1357_9BDF, 1'b0, t0 + 18, 1'b0});
        drive(0, 1, 32'h3002_0084, 32'h0, 1'b0);
        @(posedge core_clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            r = (obs_q.size() > 0) ? obs_q.pop_front() : '{1'bx, 32'hx, 1'bx, -1, 1'bx};
            if (r.idx !== e.idx || r.data !== e.data || r.err !== e.err || r.cyc !== e.cyc) begin
                n_err++;
                $display("FAIL timeout_rsp actual idx=%0d data=%h err=%b cyc=%0d required idx=%0d data=%h err=%b cyc=%0d",
                         r.idx, r.data, r.err, r.cyc, e.idx, e.data, e.err, e.cyc);
            end
        end
        n_cmp++;
        if (obs_dn.size() != 1) begin
            n_err++;
            $display("FAIL timeout_dn actual %0d slave completions required 1", obs_dn.size());
        end
        obs_dn.delete();
        slv_wait = 0;
    endtask
`else
    task automatic test_timeout();
        rsp_t e, r;
        int   t0;
        slv_wait = 20;
        slv_rdata = 32'h2468_ACE0;
        @(negedge core_clk);
        t0 = cyc;
        exp_q.push_back('{1'b0, 32'h2468_ACE0, 1'b0, t0 + 23, 1'b0});
        drive(0, 1, 32'h3002_0088, 32'h0, 1'b0);
        @(posedge core_clk);
        e = exp_q.pop_front();
        n_cmp++;
        r = (obs_q.size() > 0) ? obs_q.pop_front() : '{1'bx, 32'hx, 1'bx, -1, 1'bx};
        if (r.idx !== e.idx || r.data !== e.data || r.err !== e.err || r.cyc !== e.cyc) begin
            n_err++;
            $display("FAIL long_wait_rsp actual idx=%0d data=%h err=%b cyc=%0d required idx=%0d data=%h err=%b cyc=%0d",
                     r.idx, r.data, r.err, r.cyc, e.idx, e.data, e.err, e.cyc);
        end
        obs_dn.delete();
        slv_wait = 0;
    endtask
`endif

    task automatic test_reset_mid();
        logic hit;
        slv_wait = 10;
        @(negedge core_clk);
        s1_psel = 1'b1; s1_pwrite = 1'b1; s1_paddr = 32'h3003_00C0;
        s1_pwdata = 32'h9999_0000; s1_pprot = 3'b101; s1_pauser = 32'h5A5A_0000;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge core_clk);
            hit = m_penable;
        end
        if (!hit) begin
            n_cmp++;
            n_err++;
            $display("FAIL rst_mid_access actual penable never high required ACCESS within 20 cycles");
        end
        core_rst = 1'b1;
        @(negedge core_clk);
        n_cmp++;
        if (m_psel !== 1'b0 || m_penable !== 1'b0 || arb_busy !== 1'b0 || arb_grant !== 1'b0 || s1_pready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_outputs actual psel=%b pen=%b busy=%b grant=%b s1_pready=%b required all 0",
                     m_psel, m_penable, arb_busy, arb_grant, s1_pready);
        end
        s1_psel = 1'b0;
        core_rst = 1'b0;
        repeat (15) @(negedge core_clk);
        @(posedge core_clk);
        n_cmp++;
        if (obs_q.size() != 0 || obs_dn.size() != 0) begin
            n_err++;
            $display("FAIL rst_mid_no_rsp actual rsp=%0d dn=%0d required 0 0", obs_q.size(), obs_dn.size());
        end
        slv_wait = 0;
    endtask

    initial begin
        s0_psel = 1'b0; s0_penable = 1'b0; s0_pwrite = 1'b0; s0_paddr = '0;
        s0_pwdata = '0; s0_pprot = '0; s0_pauser = '0;
        s1_psel = 1'b0; s1_penable = 1'b0; s1_pwrite = 1'b0; s1_paddr = '0;
        s1_pwdata = '0; s1_pprot = '0; s1_pauser = '0;
        test_reset();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_wait_err();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
